// File: rtl/wb_regfile_sb_pkg.sv
// Shared definitions for the writeback register file and its pending-write scoreboard.
package wb_regfile_sb_pkg;
  localparam int WB_WIDTH = 64;
  localparam int WB_ADDR  = 5;
  localparam int WB_NREGS = 32;
  localparam int WB_SBW   = 2;
  localparam logic [WB_ADDR-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_sb_counter.sv
// One scoreboard slot: saturating up/down pending-write counter with an error strobe
// raised on an attempted overflow or underflow (count holds in that case).
module wb_sb_counter
  import wb_regfile_sb_pkg::*;
#(
  parameter int SBW = WB_SBW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           inc,
  input  logic           dec,
  output logic [SBW-1:0] cnt,
  output logic           err
);

  localparam logic [SBW-1:0] CNT_MAX = {SBW{1'b1}};
  localparam logic [SBW-1:0] CNT_ONE = {{(SBW-1){1'b0}}, 1'b1};

  logic [SBW-1:0] cnt_r;
  logic [SBW-1:0] cnt_nxt_s;
  logic           err_s;

  // next count and error strobe; flush wins over any inc/dec in the same cycle
  always_comb begin
    cnt_nxt_s = cnt_r;
    err_s     = 1'b0;
    if (flush) begin
      cnt_nxt_s = {SBW{1'b0}};
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (cnt_r == CNT_MAX) begin
            err_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        2'b01: begin
          if (cnt_r == {SBW{1'b0}}) begin
            err_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        default: cnt_nxt_s = cnt_r;
      endcase
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {SBW{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt = cnt_r;
  assign err = err_s;

endmodule

// File: rtl/wb_regfile_sb.sv
// 32 x 64-bit GPR file with two combinational read ports and a pending-write scoreboard.
// Build option REGFILE_BYPASS_EN: forward the retiring value to reads and relax the hazard.
module wb_regfile_sb
  import wb_regfile_sb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH,
  parameter int ADDR  = WB_ADDR,
  parameter int NREGS = WB_NREGS,
  parameter int SBW   = WB_SBW
) (
  input  logic             p_Clk,
  input  logic             p_Reset_n,
  input  logic [WIDTH-1:0] p_WB_WritebackData,
  input  logic [ADDR-1:0]  p_WB_RegDest,
  input  logic             p_RegWrite,
  input  logic [ADDR-1:0]  p_ID_RsAddr,
  input  logic [ADDR-1:0]  p_ID_RtAddr,
  input  logic             p_ID_RsUsed,
  input  logic             p_ID_RtUsed,
  output logic [WIDTH-1:0] p_ID_RsData,
  output logic [WIDTH-1:0] p_ID_RtData,
  input  logic             p_ID_Issue,
  input  logic             p_ID_IssueWrites,
  input  logic [ADDR-1:0]  p_ID_IssueDest,
  input  logic             p_Flush,
  output logic             p_ID_Hazard,
  output logic             p_SB_Error
);

  logic [WIDTH-1:0]          regs_r [NREGS];
  logic [NREGS-1:0][SBW-1:0] cnt_s;
  logic [NREGS-1:1]          inc_s;
  logic [NREGS-1:1]          dec_s;
  logic [NREGS-1:1]          err_s;
  logic [NREGS-1:0]          busy_s;
  logic                      retire_s;
  logic                      issue_ok_s;
  logic                      hazard_s;
  logic                      sb_error_r;
  logic [WIDTH-1:0]          rs_data_s;
  logic [WIDTH-1:0]          rt_data_s;

  assign retire_s   = p_RegWrite & (p_WB_RegDest != REG_ZERO);
  assign issue_ok_s = p_ID_Issue & p_ID_IssueWrites & ~hazard_s & (p_ID_IssueDest != REG_ZERO);

  // register array; r0 is never written so it stays zero
  always_ff @(posedge p_Clk or negedge p_Reset_n) begin
    if (!p_Reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {WIDTH{1'b0}};
      end
    end else if (retire_s) begin
      regs_r[p_WB_RegDest] <= p_WB_WritebackData;
    end
  end

  // one-hot increment/decrement requests per register
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc_s[r] = issue_ok_s & (p_ID_IssueDest == ADDR'(r));
      dec_s[r] = retire_s & (p_WB_RegDest == ADDR'(r));
    end
  end

  assign cnt_s[0] = {SBW{1'b0}};

  for (genvar g = 1; g < NREGS; g++) begin : g_sb
    wb_sb_counter #(.SBW(SBW)) u_cnt (
      .clk  (p_Clk),
      .rst_n(p_Reset_n),
      .flush(p_Flush),
      .inc  (inc_s[g]),
      .dec  (dec_s[g]),
      .cnt  (cnt_s[g]),
      .err  (err_s[g])
    );
  end

  // busy view used by the hazard check; with bypass the last in-flight writer retiring now is free
  always_comb begin
    busy_s = '0;
    for (int r = 1; r < NREGS; r++) begin
`ifdef REGFILE_BYPASS_EN
      busy_s[r] = (cnt_s[r] != {SBW{1'b0}}) &
                  ~((cnt_s[r] == {{(SBW-1){1'b0}}, 1'b1}) & dec_s[r]);
`else
      busy_s[r] = (cnt_s[r] != {SBW{1'b0}});
`endif
    end
  end

  // stall request to ID
  always_comb begin
    hazard_s = (p_ID_RsUsed & busy_s[p_ID_RsAddr]) | (p_ID_RtUsed & busy_s[p_ID_RtAddr]);
  end

  // sticky over/underflow flag, cleared only by reset
  always_ff @(posedge p_Clk or negedge p_Reset_n) begin
    if (!p_Reset_n) begin
      sb_error_r <= 1'b0;
    end else begin
      sb_error_r <= sb_error_r | (|err_s);
    end
  end

  // read ports; forced to zero while reset is asserted so a forwarded retire cannot leak out
  always_comb begin
    rs_data_s = regs_r[p_ID_RsAddr];
    rt_data_s = regs_r[p_ID_RtAddr];
`ifdef REGFILE_BYPASS_EN
    if (retire_s && (p_WB_RegDest == p_ID_RsAddr)) begin
      rs_data_s = p_WB_WritebackData;
    end else begin
      rs_data_s = regs_r[p_ID_RsAddr];
    end
    if (retire_s && (p_WB_RegDest == p_ID_RtAddr)) begin
      rt_data_s = p_WB_WritebackData;
    end else begin
      rt_data_s = regs_r[p_ID_RtAddr];
    end
`endif
    if (!p_Reset_n || (p_ID_RsAddr == REG_ZERO)) begin
      rs_data_s = {WIDTH{1'b0}};
    end else begin
      rs_data_s = rs_data_s;
    end
    if (!p_Reset_n || (p_ID_RtAddr == REG_ZERO)) begin
      rt_data_s = {WIDTH{1'b0}};
    end else begin
      rt_data_s = rt_data_s;
    end
  end

  assign p_ID_RsData = rs_data_s;
  assign p_ID_RtData = rt_data_s;
  assign p_ID_Hazard = hazard_s;
  assign p_SB_Error  = sb_error_r;

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Self-checking bench for wb_regfile_sb: directed scenarios then randomized traffic
// against a behavioural model (register array + pending counts held as integers).
module tb_wb_regfile_sb;

  logic        p_Clk;
  logic        p_Reset_n;
  logic [63:0] p_WB_WritebackData;
  logic [4:0]  p_WB_RegDest;
  logic        p_RegWrite;
  logic [4:0]  p_ID_RsAddr;
  logic [4:0]  p_ID_RtAddr;
  logic        p_ID_RsUsed;
  logic        p_ID_RtUsed;
  logic [63:0] p_ID_RsData;
  logic [63:0] p_ID_RtData;
  logic        p_ID_Issue;
  logic        p_ID_IssueWrites;
  logic [4:0]  p_ID_IssueDest;
  logic        p_Flush;
  logic        p_ID_Hazard;
  logic        p_SB_Error;

  int          n_cmp;
  int          n_mis;
  logic [63:0] m_reg [32];
  int          m_cnt [32];
  bit          m_err;

  wb_regfile_sb dut (
    .p_Clk             (p_Clk),
    .p_Reset_n         (p_Reset_n),
    .p_WB_WritebackData(p_WB_WritebackData),
    .p_WB_RegDest      (p_WB_RegDest),
    .p_RegWrite        (p_RegWrite),
    .p_ID_RsAddr       (p_ID_RsAddr),
    .p_ID_RtAddr       (p_ID_RtAddr),
    .p_ID_RsUsed       (p_ID_RsUsed),
    .p_ID_RtUsed       (p_ID_RtUsed),
    .p_ID_RsData       (p_ID_RsData),
    .p_ID_RtData       (p_ID_RtData),
    .p_ID_Issue        (p_ID_Issue),
    .p_ID_IssueWrites  (p_ID_IssueWrites),
    .p_ID_IssueDest    (p_ID_IssueDest),
    .p_Flush           (p_Flush),
    .p_ID_Hazard       (p_ID_Hazard),
    .p_SB_Error        (p_SB_Error)
  );

  initial p_Clk = 1'b0;
  always #5 p_Clk = ~p_Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int r);
    if (r == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (m_cnt[r] == 1 && p_RegWrite && int'(p_WB_RegDest) == r) return 1'b0;
`endif
    return m_cnt[r] != 0;
  endfunction

  function automatic bit m_hazard();
    return (p_ID_RsUsed && m_busy(int'(p_ID_RsAddr))) || (p_ID_RtUsed && m_busy(int'(p_ID_RtAddr)));
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (p_RegWrite && p_WB_RegDest == a) return p_WB_WritebackData;
`endif
    return m_reg[a];
  endfunction

  function automatic void m_clear();
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = 64'd0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
  endfunction

  // apply one clock edge of the architectural rules to the model
  function automatic void m_step();
    int ir;
    int dr;
    ir = (p_ID_Issue && p_ID_IssueWrites && !m_hazard() && p_ID_IssueDest != 5'd0) ? int'(p_ID_IssueDest) : 0;
    dr = (p_RegWrite && p_WB_RegDest != 5'd0) ? int'(p_WB_RegDest) : 0;
    if (dr != 0) m_reg[dr] = p_WB_WritebackData;
    if (p_Flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end else if (!(ir != 0 && ir == dr)) begin
      if (ir != 0) begin
        if (m_cnt[ir] == 3) m_err = 1'b1;
        else m_cnt[ir]++;
      end
      if (dr != 0) begin
        if (m_cnt[dr] == 0) m_err = 1'b1;
        else m_cnt[dr]--;
      end
    end
  endfunction

  task automatic idle();
    p_WB_WritebackData = 64'd0;
    p_WB_RegDest       = 5'd0;
    p_RegWrite         = 1'b0;
    p_ID_RsAddr        = 5'd0;
    p_ID_RtAddr        = 5'd0;
    p_ID_RsUsed        = 1'b0;
    p_ID_RtUsed        = 1'b0;
    p_ID_Issue         = 1'b0;
    p_ID_IssueWrites   = 1'b0;
    p_ID_IssueDest     = 5'd0;
    p_Flush            = 1'b0;
  endtask

  // check outputs against the model, advance one clock, return at the next falling edge
  task automatic cycle();
    #1;
    check("rs_data", p_ID_RsData, m_read(p_ID_RsAddr));
    check("rt_data", p_ID_RtData, m_read(p_ID_RtAddr));
    check("hazard", {63'd0, p_ID_Hazard}, {63'd0, m_hazard()});
    check("sb_error", {63'd0, p_SB_Error}, {63'd0, m_err});
    m_step();
    @(negedge p_Clk);
  endtask

  task automatic do_reset();
    p_Reset_n = 1'b0;
    #1;
    check("rst_rs_data", p_ID_RsData, 64'd0);
    check("rst_rt_data", p_ID_RtData, 64'd0);
    check("rst_hazard", {63'd0, p_ID_Hazard}, 64'd0);
    check("rst_sb_error", {63'd0, p_SB_Error}, 64'd0);
    m_clear();
    @(negedge p_Clk);
    p_Reset_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    idle();
    m_clear();
    p_Reset_n = 1'b0;
    @(negedge p_Clk);
    @(negedge p_Clk);
    p_Reset_n = 1'b1;

    // reset mid-run after a write to r5 and a pending writer on r5
    p_RegWrite = 1'b1; p_WB_RegDest = 5'd5; p_WB_WritebackData = 64'h1234_5678_9ABC_DEF0;
    cycle();
    idle();
    p_ID_Issue = 1'b1; p_ID_IssueWrites = 1'b1; p_ID_IssueDest = 5'd5;
    cycle();
    idle();
    p_ID_RsAddr = 5'd5; p_ID_RsUsed = 1'b1;
    #1 check("pre_rst_hazard", {63'd0, p_ID_Hazard}, 64'd1);
    do_reset();
    cycle();

    // write/read and r0 protection
    idle();
    p_RegWrite = 1'b1; p_WB_RegDest = 5'd7; p_WB_WritebackData = 64'hDEAD_BEEF_0123_4567;
    p_ID_RtAddr = 5'd7;
    cycle();
    idle();
    p_ID_RsAddr = 5'd7;
    #1 check("r7_read", p_ID_RsData, 64'hDEAD_BEEF_0123_4567);
    cycle();
    p_RegWrite = 1'b1; p_WB_RegDest = 5'd0; p_WB_WritebackData = 64'hFFFF_FFFF_FFFF_FFFF;
    p_ID_RsAddr = 5'd0;
    cycle();
    idle();
    #1 check("r0_read", p_ID_RsData, 64'd0);
    cycle();

    // RAW stall on r3
    p_ID_Issue = 1'b1; p_ID_IssueWrites = 1'b1; p_ID_IssueDest = 5'd3;
    cycle();
    idle();
    p_ID_RsAddr = 5'd3; p_ID_RsUsed = 1'b1;
    #1 check("raw_hazard", {63'd0, p_ID_Hazard}, 64'd1);
    cycle();
    p_RegWrite = 1'b1; p_WB_RegDest = 5'd3; p_WB_WritebackData = 64'hA5A5_0000_1111_3333;
`ifdef REGFILE_BYPASS_EN
    #1 check("raw_retire_hazard", {63'd0, p_ID_Hazard}, 64'd0);
`else
    #1 check("raw_retire_hazard", {63'd0, p_ID_Hazard}, 64'd1);
`endif
    cycle();
    idle();
    p_ID_RsAddr = 5'd3; p_ID_RsUsed = 1'b1;
    #1 check("raw_after_hazard", {63'd0, p_ID_Hazard}, 64'd0);
    cycle();

    // simultaneous inc/dec on r9 with one in flight
    idle();
    p_ID_Issue = 1'b1; p_ID_IssueWrites = 1'b1; p_ID_IssueDest = 5'd9;
    cycle();
    p_RegWrite = 1'b1; p_WB_RegDest = 5'd9; p_WB_WritebackData = 64'h9;
    cycle();
    idle();
    p_ID_RsAddr = 5'd9; p_ID_RsUsed = 1'b1;
    #1 check("incdec_hazard", {63'd0, p_ID_Hazard}, 64'd1);
    cycle();
    idle();
    p_RegWrite = 1'b1; p_WB_RegDest = 5'd9;
    cycle();
    idle();

    // overflow on r4
    p_ID_Issue = 1'b1; p_ID_IssueWrites = 1'b1; p_ID_IssueDest = 5'd4;
    for (int i = 0; i < 4; i++) cycle();
    idle();
    #1 check("ovf_error", {63'd0, p_SB_Error}, 64'd1);
    p_Flush = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < 2; i++) cycle();
    check("ovf_sticky", {63'd0, p_SB_Error}, 64'd1);

    // underflow on r6 after a fresh reset
    do_reset();
    p_RegWrite = 1'b1; p_WB_RegDest = 5'd6; p_WB_WritebackData = 64'h66;
    cycle();
    idle();
    #1 check("unf_error", {63'd0, p_SB_Error}, 64'd1);
    do_reset();

    // flush with a colliding issue
    idle();
    p_ID_Issue = 1'b1; p_ID_IssueWrites = 1'b1; p_ID_IssueDest = 5'd2;
    cycle();
    cycle();
    p_ID_IssueDest = 5'd8;
    cycle();
    p_ID_IssueDest = 5'd2; p_Flush = 1'b1;
    cycle();
    idle();
    p_ID_RsAddr = 5'd2; p_ID_RsUsed = 1'b1; p_ID_RtAddr = 5'd8; p_ID_RtUsed = 1'b1;
    #1 check("flush_hazard", {63'd0, p_ID_Hazard}, 64'd0);
    check("flush_no_error", {63'd0, p_SB_Error}, 64'd0);
    cycle();

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      p_WB_WritebackData = {$urandom, $urandom};
      p_WB_RegDest       = 5'($urandom_range(0, 7));
      p_RegWrite         = ($urandom_range(0, 9) < 4);
      p_ID_RsAddr        = 5'($urandom_range(0, 9));
      p_ID_RtAddr        = 5'($urandom_range(0, 9));
      p_ID_RsUsed        = 1'($urandom);
      p_ID_RtUsed        = 1'($urandom);
      p_ID_Issue         = 1'($urandom);
      p_ID_IssueWrites   = ($urandom_range(0, 3) != 0);
      p_ID_IssueDest     = 5'($urandom_range(0, 7));
      p_Flush            = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
